// File: rtl/mult_lane_pipe_if.sv
// Operand/result bus of the multi-lane MAC pipeline: operand beat in (valid/ready/last),
// accumulated packet result out (valid/ready), plus status flags.
interface mult_lane_pipe_if #(
    parameter int BIT_WIDTH = 8,
    parameter int N_LANES   = 4,
    parameter int ACC_WIDTH = 2*BIT_WIDTH+8
);
    logic                           i_valid;
    logic                           o_ready;
    logic                           i_last;
    logic [N_LANES*BIT_WIDTH-1:0]   i_weight;
    logic [N_LANES*BIT_WIDTH-1:0]   i_feature;
    logic                           o_valid;
    logic                           i_ready;
    logic [N_LANES*ACC_WIDTH-1:0]   o_acc;
    logic                           o_start;
    logic                           o_busy;
    logic                           o_init;

    modport slave (
        input  i_valid, i_last, i_weight, i_feature, i_ready,
        output o_ready, o_valid, o_acc, o_start, o_busy, o_init
    );

    modport master (
        output i_valid, i_last, i_weight, i_feature, i_ready,
        input  o_ready, o_valid, o_acc, o_start, o_busy, o_init
    );
endinterface

// File: rtl/mult_lane_pipe.sv
// Multi-lane multiply-accumulate pipeline; per-packet sums, one result beat per packet.
// MULT_SIGNED_EN selects two's-complement operands with sign-extended products.
module mult_lane_pipe_lane #(
    parameter int BIT_WIDTH   = 8,
    parameter int PIPE_STAGES = 2,
    parameter int ACC_WIDTH   = 2*BIT_WIDTH+8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 ld,
    input  logic                 adv,
    input  logic                 acc_en,
    input  logic                 first,
    input  logic                 last,
    input  logic [BIT_WIDTH-1:0] w,
    input  logic [BIT_WIDTH-1:0] f,
    output logic [ACC_WIDTH-1:0] res
);
    localparam int PW = 2*BIT_WIDTH;

    typedef struct packed {
        logic [BIT_WIDTH-1:0] w;
        logic [BIT_WIDTH-1:0] f;
    } op_t;

    op_t                  op_q;
    logic [PW-1:0]        prod_c;
    logic [PW-1:0]        prod_out;
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            op_q <= '0;
        else if (ld)
            op_q <= '{w: w, f: f};
    end

`ifdef MULT_SIGNED_EN
    logic signed [PW-1:0] ws;
    logic signed [PW-1:0] fs;
    assign ws     = {{BIT_WIDTH{op_q.w[BIT_WIDTH-1]}}, op_q.w};
    assign fs     = {{BIT_WIDTH{op_q.f[BIT_WIDTH-1]}}, op_q.f};
    assign prod_c = ws * fs;
    assign ext    = {{(ACC_WIDTH-PW){prod_out[PW-1]}}, prod_out};
`else
    assign prod_c = {{BIT_WIDTH{1'b0}}, op_q.w} * {{BIT_WIDTH{1'b0}}, op_q.f};
    assign ext    = {{(ACC_WIDTH-PW){1'b0}}, prod_out};
`endif

    // Stage 1 holds operands; the remaining PIPE_STAGES-1 stages carry the product.
    if (PIPE_STAGES > 1) begin : g_pipe
        logic [PIPE_STAGES-2:0][PW-1:0] prod_q;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                prod_q <= '0;
            end else if (adv) begin
                prod_q[0] <= prod_c;
                for (int k = 1; k < PIPE_STAGES-1; k++)
                    prod_q[k] <= prod_q[k-1];
            end
        end
        assign prod_out = prod_q[PIPE_STAGES-2];
    end else begin : g_nopipe
        assign prod_out = prod_c;
    end

    assign acc_nxt = (first ? '0 : acc) + ext;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc <= '0;
            res <= '0;
        end else if (acc_en) begin
            acc <= acc_nxt;
            if (last)
                res <= acc_nxt;
        end
    end
endmodule

module mult_lane_pipe #(
    parameter int BIT_WIDTH   = 8,
    parameter int N_LANES     = 4,
    parameter int PIPE_STAGES = 2,
    parameter int ACC_WIDTH   = 2*BIT_WIDTH+8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mult_lane_pipe_if.slave bus
);
    logic                                stall;
    logic                                accept;
    logic                                acc_en;
    logic                                res_ld;
    logic [PIPE_STAGES:1]                vld_pipe;
    logic [PIPE_STAGES:1]                lst_pipe;
    logic                                first;
    logic                                in_first;
    logic                                out_vld;
    logic                                start_q;
    logic                                init_q;
    logic [N_LANES-1:0][BIT_WIDTH-1:0]   w_v;
    logic [N_LANES-1:0][BIT_WIDTH-1:0]   f_v;
    logic [N_LANES-1:0][ACC_WIDTH-1:0]   acc_v;

    assign w_v    = bus.i_weight;
    assign f_v    = bus.i_feature;
    assign stall  = out_vld & ~bus.i_ready;
    assign accept = bus.i_valid & ~stall;
    assign acc_en = vld_pipe[PIPE_STAGES] & ~stall;
    assign res_ld = acc_en & lst_pipe[PIPE_STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe <= '0;
            lst_pipe <= '0;
        end else if (!stall) begin
            vld_pipe[1] <= accept;
            lst_pipe[1] <= accept & bus.i_last;
            for (int k = 2; k <= PIPE_STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                lst_pipe[k] <= lst_pipe[k-1];
            end
        end
    end

    // first tracks the accumulator side, in_first the input side (for o_start).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            first    <= 1'b1;
            in_first <= 1'b1;
            out_vld  <= 1'b0;
            start_q  <= 1'b0;
            init_q   <= 1'b1;
        end else begin
            start_q <= accept & in_first;
            if (accept)
                in_first <= bus.i_last;
            if (acc_en)
                first <= lst_pipe[PIPE_STAGES];
            if (res_ld) begin
                out_vld <= 1'b1;
                init_q  <= 1'b0;
            end else if (out_vld && bus.i_ready) begin
                out_vld <= 1'b0;
            end
        end
    end

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        mult_lane_pipe_lane #(
            .BIT_WIDTH   (BIT_WIDTH),
            .PIPE_STAGES (PIPE_STAGES),
            .ACC_WIDTH   (ACC_WIDTH)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .ld      (accept),
            .adv     (~stall),
            .acc_en  (acc_en),
            .first   (first),
            .last    (lst_pipe[PIPE_STAGES]),
            .w       (w_v[l]),
            .f       (f_v[l]),
            .res     (acc_v[l])
        );
    end

    assign bus.o_ready = ~stall;
    assign bus.o_valid = out_vld;
    assign bus.o_acc   = acc_v;
    assign bus.o_start = start_q;
    assign bus.o_busy  = (|vld_pipe) | ~first;
    assign bus.o_init  = init_q;
endmodule

// File: tb/tb_mult_lane_pipe.sv
// Directed-vector bench for mult_lane_pipe: 2 lanes, 8-bit operands, 2 stages, 24-bit sums.
module tb_mult_lane_pipe;
    localparam int BW = 8;
    localparam int NL = 2;
    localparam int PS = 2;
    localparam int AW = 24;

`ifdef MULT_SIGNED_EN
    localparam int EXP_T1_L1 = 1;
    localparam int EXP_WRAP  = 259;
`else
    localparam int EXP_T1_L1 = 65025;
    localparam int EXP_WRAP  = 64259;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mult_lane_pipe_if #(.BIT_WIDTH(BW), .N_LANES(NL), .ACC_WIDTH(AW)) bus ();

    mult_lane_pipe #(
        .BIT_WIDTH   (BW),
        .N_LANES     (NL),
        .PIPE_STAGES (PS),
        .ACC_WIDTH   (AW)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    logic [AW-1:0] acc0, acc1;
    assign acc0 = bus.o_acc[AW-1:0];
    assign acc1 = bus.o_acc[2*AW-1:AW];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic l,
                         input logic [7:0] w0, input logic [7:0] f0,
                         input logic [7:0] w1, input logic [7:0] f1);
        bus.i_valid   = v;
        bus.i_last    = l;
        bus.i_weight  = {w1, w0};
        bus.i_feature = {f1, f0};
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(bus.o_valid), 0);
        chk({tag, "_acc"},   32'(bus.o_acc != '0), 0);
        chk({tag, "_start"}, 32'(bus.o_start), 0);
        chk({tag, "_busy"},  32'(bus.o_busy), 0);
        chk({tag, "_init"},  32'(bus.o_init), 1);
        chk({tag, "_ready"}, 32'(bus.o_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.i_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) tick;
        chk_reset("rst");
        rst_n = 1'b1;
        tick;

        // single beat: latency 2, o_start pulse, o_init falls
        drive(1, 1, 3, 5, 255, 255);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("t1_start", 32'(bus.o_start), 1);
        chk("t1_busy",  32'(bus.o_busy), 1);
        chk("t1_v0",    32'(bus.o_valid), 0);
        tick;
        chk("t1_start_end", 32'(bus.o_start), 0);
        chk("t1_v1",        32'(bus.o_valid), 0);
        tick;
        chk("t1_v2",    32'(bus.o_valid), 1);
        chk("t1_l0",    32'(acc0), 15);
        chk("t1_l1",    32'(acc1), EXP_T1_L1);
        chk("t1_init",  32'(bus.o_init), 0);
        chk("t1_idle",  32'(bus.o_busy), 0);
        tick;
        chk("t1_clr",   32'(bus.o_valid), 0);

        // four-beat packet
        for (int i = 0; i < 4; i++) begin
            drive(1, i == 3, 10, 8'(i + 1), 2, 5);
            tick;
            chk("t2_busy", 32'(bus.o_busy), 1);
            chk("t2_nov",  32'(bus.o_valid), 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick;
        chk("t2_v1",   32'(bus.o_valid), 0);
        chk("t2_busy", 32'(bus.o_busy), 1);
        tick;
        chk("t2_v2", 32'(bus.o_valid), 1);
        chk("t2_l0", 32'(acc0), 100);
        chk("t2_l1", 32'(acc1), 40);
        tick;
        chk("t2_once", 32'(bus.o_valid), 0);

        // backpressure: A on output, B in flight, C held at the input
        drive(1, 1, 4, 4, 1, 1);
        tick;
        drive(1, 1, 3, 7, 5, 5);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        tick;
        chk("bp_a_v",  32'(bus.o_valid), 1);
        chk("bp_a_l0", 32'(acc0), 16);
        bus.i_ready = 1'b0;
        drive(1, 1, 6, 6, 2, 9);
        #1;
        chk("bp_rdy0", 32'(bus.o_ready), 0);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("bp_hold_v",   32'(bus.o_valid), 1);
            chk("bp_hold_l0",  32'(acc0), 16);
            chk("bp_hold_l1",  32'(acc1), 1);
            chk("bp_hold_rdy", 32'(bus.o_ready), 0);
            chk("bp_hold_bsy", 32'(bus.o_busy), 1);
        end
        bus.i_ready = 1'b1;
        #1;
        chk("bp_rdy1", 32'(bus.o_ready), 1);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("bp_b_v",  32'(bus.o_valid), 1);
        chk("bp_b_l0", 32'(acc0), 21);
        chk("bp_b_l1", 32'(acc1), 25);
        tick;
        chk("bp_gap", 32'(bus.o_valid), 0);
        tick;
        chk("bp_c_v",  32'(bus.o_valid), 1);
        chk("bp_c_l0", 32'(acc0), 36);
        chk("bp_c_l1", 32'(acc1), 18);

        // 259 beats of 255*255 wrap modulo 2^24
        for (int i = 0; i < 259; i++) begin
            drive(1, i == 258, 255, 255, 1, 1);
            tick;
        end
        drive(0, 0, 0, 0, 0, 0);
        n = 0;
        while (!bus.o_valid && n < 10) begin
            tick;
            n++;
        end
        chk("wrap_v",   32'(bus.o_valid), 1);
        chk("wrap_lat", 32'(n), 2);
        chk("wrap_l0",  32'(acc0), EXP_WRAP);
        chk("wrap_l1",  32'(acc1), 259);

        // back-to-back single-beat packets
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1, 1, 1, 8'(i + 1), 2, 8'(i + 1));
            else       drive(0, 0, 0, 0, 0, 0);
            tick;
            if (i >= 2) begin
                chk("b2b_v",  32'(bus.o_valid), 1);
                chk("b2b_l0", 32'(acc0), 32'(i - 1));
                chk("b2b_l1", 32'(acc1), 32'(2 * (i - 1)));
            end else begin
                chk("b2b_pre", 32'(bus.o_valid), 0);
            end
        end
        tick;
        chk("b2b_end", 32'(bus.o_valid), 0);

        // reset in the middle of an open packet
        drive(1, 0, 9, 9, 3, 3);
        tick;
        tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("mr_busy", 32'(bus.o_busy), 1);
        rst_n = 1'b0;
        #1;
        chk_reset("mr");
        tick;
        rst_n = 1'b1;
        tick;
        drive(1, 1, 2, 2, 3, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("mr_start", 32'(bus.o_start), 1);
        tick;
        tick;
        chk("mr_v",    32'(bus.o_valid), 1);
        chk("mr_l0",   32'(acc0), 4);
        chk("mr_l1",   32'(acc1), 3);
        chk("mr_init", 32'(bus.o_init), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
